// File: rtl/irq_timer.sv
// Memory-mapped 32-bit reload timer with a sticky interrupt (TH, TL, TCON).
// Optional tick prescaler is enabled by defining TIMER_PRESCALE_EN.
module irq_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWr,
  input  logic        MemRd,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [29:0] W_TH = BASE_ADDR[31:2];
  localparam logic [29:0] W_TL = W_TH + 30'd1;
  localparam logic [29:0] W_TC = W_TH + 30'd2;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        sel_th, sel_tl, sel_tc;
  logic        wr_th, wr_tl, wr_tc;
  logic        tick, ovf;
  logic        unused_ok;

  assign sel_th = (addr[31:2] == W_TH);
  assign sel_tl = (addr[31:2] == W_TL);
  assign sel_tc = (addr[31:2] == W_TC);
  assign hit    = sel_th | sel_tl | sel_tc;

  assign wr_th = MemWr & sel_th;
  assign wr_tl = MemWr & sel_tl;
  assign wr_tc = MemWr & sel_tc;

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [15:0] ps_q, ps_d;

  assign tick = tcon_q[0] & (ps_q == PS_MAX);

  always_comb begin
    ps_d = ps_q;
    if (wr_tl) begin
      ps_d = 16'h0;
    end else if (tcon_q[0]) begin
      ps_d = tick ? 16'h0 : ps_q + 16'h1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q <= 16'h0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign unused_ok = ^addr[1:0];
`else
  assign tick      = tcon_q[0];
  assign unused_ok = ^{addr[1:0], 16'(PRESCALE)};
`endif

  assign ovf = tick & (tl_q == 32'hFFFF_FFFF);

  // Overflow always wins bit 2 so a pending interrupt cannot be lost.
  always_comb begin
    th_d   = wr_th ? wdata : th_q;
    tl_d   = tl_q;
    tcon_d = wr_tc ? wdata[2:0] : tcon_q;
    if (wr_tl) begin
      tl_d = wdata;
    end else if (tick) begin
      tl_d = ovf ? th_q : tl_q + 32'h1;
    end
    if (ovf && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= 32'h0;
      tl_q   <= 32'h0;
      tcon_q <= 3'b000;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign irq = tcon_q[2];

  always_comb begin
    rdata = 32'h0;
    if (MemRd) begin
      unique case (1'b1)
        sel_th:  rdata = th_q;
        sel_tl:  rdata = tl_q;
        sel_tc:  rdata = {29'h0, tcon_q};
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer.sv
// Directed self-checking bench for irq_timer.
// Define TIMER_PRESCALE_EN to also exercise the prescaler with PRESCALE=4.
module tb_irq_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE;
  localparam logic [31:0] A_TL = BASE + 32'd4;
  localparam logic [31:0] A_TC = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        MemWr = 1'b0;
  logic        MemRd = 1'b0;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int total = 0;
  int passed = 0;

  irq_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .MemWr (MemWr),
    .MemRd (MemRd),
    .rdata (rdata),
    .hit   (hit),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    MemWr = 1'b1;
    @(posedge clk);
    #1;
    MemWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic h);
    addr  = a;
    MemRd = 1'b1;
    #1;
    d     = rdata;
    h     = hit;
    MemRd = 1'b0;
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] v;
  logic        h;

  initial begin
    // Reset state
    #12;
    rd(A_TH, v, h); check("rst_th", v, 32'h0);
    rd(A_TL, v, h); check("rst_tl", v, 32'h0);
    rd(A_TC, v, h); check("rst_tcon", v, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Overflow with interrupt enabled
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h3);
    rd(A_TL, v, h); check("setup_tl", v, 32'hFFFF_FFFE);
    clk_n(1);
    rd(A_TL, v, h); check("tl_ff", v, 32'hFFFF_FFFF);
    check("irq_pre", {31'h0, irq}, 32'h0);
    clk_n(1);
    rd(A_TL, v, h); check("wrap_tl", v, 32'hFFFF_FFF0);
    check("wrap_irq", {31'h0, irq}, 32'h1);
    clk_n(16);
    rd(A_TL, v, h); check("wrap2_tl", v, 32'hFFFF_FFF0);
    check("wrap2_irq", {31'h0, irq}, 32'h1);

    // TCON write on overflow edge keeps status
    clk_n(15);
    rd(A_TL, v, h); check("pre_ovf_tl", v, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3);
    rd(A_TC, v, h); check("tcon_ovf_wr", v, 32'h7);
    check("irq_kept", {31'h0, irq}, 32'h1);
    rd(A_TL, v, h); check("tl_ovf_wr", v, 32'hFFFF_FFF0);
    wr(A_TC, 32'h5);
    check("irq_ie_off", {31'h0, irq}, 32'h1);
    wr(A_TC, 32'h3);
    check("irq_clear", {31'h0, irq}, 32'h0);
    rd(A_TC, v, h); check("tcon_clear", v, 32'h3);

    // Overflow with interrupt disabled
    wr(A_TC, 32'h0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h1);
    clk_n(2);
    rd(A_TL, v, h); check("noie_tl", v, 32'hFFFF_FFF0);
    check("noie_irq", {31'h0, irq}, 32'h0);
    rd(A_TC, v, h); check("noie_tcon", v, 32'h1);

    // TH write on overflow edge: TL loads old TH
    wr(A_TL, 32'hFFFF_FFFE);
    clk_n(1);
    wr(A_TH, 32'h0000_1234);
    rd(A_TL, v, h); check("old_th_tl", v, 32'hFFFF_FFF0);
    rd(A_TH, v, h); check("new_th", v, 32'h0000_1234);

    // TL write on tick edge wins, then counts
    wr(A_TL, 32'h10);
    rd(A_TL, v, h); check("tl_wr_tick", v, 32'h10);
    clk_n(1);
    rd(A_TL, v, h); check("tl_inc", v, 32'h11);

    // Clearing enable still ticks on that edge
    wr(A_TC, 32'h0);
    rd(A_TL, v, h); check("stop_tick", v, 32'h12);
    clk_n(3);
    rd(A_TL, v, h); check("stop_hold", v, 32'h12);

    // Address decode
    rd(BASE + 32'd12, v, h);
    check("miss_rdata", v, 32'h0);
    check("miss_hit", {31'h0, h}, 32'h0);
    wr(BASE + 32'd12, 32'hDEAD_BEEF);
    rd(A_TH, v, h); check("miss_wr_th", v, 32'h0000_1234);
    rd(BASE + 32'd5, v, h);
    check("unalign_rd", v, 32'h12);
    check("unalign_hit", {31'h0, h}, 32'h1);
    addr = A_TH;
    #1;
    check("no_rd_zero", rdata, 32'h0);

`ifdef TIMER_PRESCALE_EN
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h1);
    clk_n(3);
    rd(A_TL, v, h); check("ps_3", v, 32'h0);
    clk_n(1);
    rd(A_TL, v, h); check("ps_4", v, 32'h1);
    clk_n(4);
    rd(A_TL, v, h); check("ps_8", v, 32'h2);
    wr(A_TC, 32'h0);
`endif

    // Reset mid-count
    wr(A_TL, 32'h5);
    wr(A_TC, 32'h3);
    clk_n(1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    rd(A_TL, v, h); check("mid_rst_tl", v, 32'h0);
    rd(A_TH, v, h); check("mid_rst_th", v, 32'h0);
    rd(A_TC, v, h); check("mid_rst_tcon", v, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    clk_n(3);
    rd(A_TL, v, h); check("post_rst_hold", v, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
